// File: rtl/seven_segment_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver with a one-cycle blank between digits.
// Optional feature macro: LEADING_ZERO_BLANK_EN (darkens leading zero digits).
module seven_segment_scan_mux #(
    parameter int N_DIGITS       = 4,
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic [4*N_DIGITS-1:0]   Hex_in,
    input  logic [N_DIGITS-1:0]     Dp_in,
    input  logic [N_DIGITS-1:0]     Digit_en,
    output logic [7:0]              Seven_segment_out,
    output logic [N_DIGITS-1:0]     Seven_segment_sel,
    output logic                    Scan_tick
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [PRE_W-1:0]    LAST_PRE = PRE_W'(CLK_DIV - 1);
    localparam logic [7:0]          SEG_OFF  = {8{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] SEL_OFF  = {N_DIGITS{SEL_ACTIVE_LOW}};

    typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [PRE_W-1:0]     presc_reg, presc_next;
    logic                 tick_reg;
    logic [7:0]           seg_reg, seg_next;
    logic [N_DIGITS-1:0]  sel_reg, sel_next;

    logic [3:0]           nibble [N_DIGITS];
    logic [N_DIGITS-1:0]  lz_dark;
    logic [N_DIGITS-1:0]  digit_on;
    logic [3:0]           nib_sel;
    logic                 dp_sel;
    logic                 on_sel;
    logic [N_DIGITS-1:0]  onehot;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign nibble[gi] = Hex_in[4*gi +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            // A digit is a leading zero when it and every more significant nibble are 0.
            if (gi == 0) begin : g_lsd
                assign lz_dark[gi] = 1'b0;
            end else begin : g_upper
                assign lz_dark[gi] = ~|Hex_in[4*N_DIGITS-1:4*gi];
            end
`else
            assign lz_dark[gi] = 1'b0;
`endif
            assign digit_on[gi] = Digit_en[gi] & ~lz_dark[gi];
        end
    endgenerate

    assign presc_next = (presc_reg == LAST_PRE) ? '0 : presc_reg + PRE_W'(1);

    always_ff @(posedge clk) begin
        if (RESET) begin
            presc_reg <= '0;
            tick_reg  <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            tick_reg  <= (presc_next == LAST_PRE);
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg <= ST_BLANK;
            idx_reg   <= LAST_IDX;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // The digit index advances on leaving BLANK, so reset's LAST_IDX makes digit 0 come first.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_BLANK: begin
                state_next = ST_DRIVE;
                idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
            end
            ST_DRIVE: begin
                if (tick_reg) begin
                    state_next = ST_BLANK;
                end
            end
            default: state_next = ST_BLANK;
        endcase
    end

    // Outputs are computed from the upcoming state so the registered pins line up with it.
    always_comb begin
        seg_next = SEG_OFF;
        sel_next = SEL_OFF;
        nib_sel  = 4'h0;
        dp_sel   = 1'b0;
        on_sel   = 1'b0;
        onehot   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) begin
                nib_sel   = nibble[i];
                dp_sel    = Dp_in[i];
                on_sel    = digit_on[i];
                onehot[i] = 1'b1;
            end
        end
        if (state_next == ST_DRIVE && on_sel) begin
            seg_next = {dp_sel, hex_to_seg(nib_sel)} ^ SEG_OFF;
            sel_next = onehot ^ SEL_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            seg_reg <= SEG_OFF;
            sel_reg <= SEL_OFF;
        end else begin
            seg_reg <= seg_next;
            sel_reg <= sel_next;
        end
    end

    assign Seven_segment_out = seg_reg;
    assign Seven_segment_sel = sel_reg;
    assign Scan_tick         = tick_reg;

endmodule

// File: tb/tb_seven_segment_scan_mux.sv
// Bench for seven_segment_scan_mux: directed scenarios plus randomized stimulus,
// every cycle checked against a slot-arithmetic model of the display.
module tb_seven_segment_scan_mux;
    localparam int N  = 4;
    localparam int CD = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_ON = 1'b1;
`else
    localparam bit LZ_ON = 1'b0;
`endif
    localparam logic [6:0] DEC_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        RESET;
    logic [15:0] Hex_in;
    logic [3:0]  Dp_in;
    logic [3:0]  Digit_en;
    logic [7:0]  Seven_segment_out;
    logic [3:0]  Seven_segment_sel;
    logic        Scan_tick;

    always #5 clk = ~clk;

    seven_segment_scan_mux #(
        .N_DIGITS       (N),
        .CLK_DIV        (CD),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk               (clk),
        .RESET             (RESET),
        .Hex_in            (Hex_in),
        .Dp_in             (Dp_in),
        .Digit_en          (Digit_en),
        .Seven_segment_out (Seven_segment_out),
        .Seven_segment_sel (Seven_segment_sel),
        .Scan_tick         (Scan_tick)
    );

    // Model state: cycles since the last reset edge plus the inputs seen at that edge.
    int          t;
    bit          valid;
    logic [15:0] hex_s;
    logic [3:0]  dp_s;
    logic [3:0]  en_s;
    int          phase;
    int          checks;
    int          passed;

    function automatic bit lz_dark(input int d, input logic [15:0] h);
        return LZ_ON && (d > 0) && ((h >> (4 * d)) == 16'h0000);
    endfunction

    initial begin
        t     = 0;
        valid = 1'b0;
        forever begin
            @(posedge clk);
            if (RESET) begin
                t     = 0;
                valid = 1'b1;
            end else if (valid) begin
                t = t + 1;
            end
            hex_s = Hex_in;
            dp_s  = Dp_in;
            en_s  = Digit_en;
        end
    end

    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] want);
        checks = checks + 1;
        if (got === want) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s t=%0d phase=%0d got tick=%0b sel=%h out=%h want tick=%0b sel=%h out=%h",
                     name, t, phase, got[12], got[11:8], got[7:0], want[12], want[11:8], want[7:0]);
        end
    endtask

    task automatic lit(input string name, input logic [12:0] want);
        $display("lit %s t=%0d tick=%0b sel=%h out=%h", name, t, Scan_tick, Seven_segment_sel, Seven_segment_out);
        chk(name, {Scan_tick, Seven_segment_sel, Seven_segment_out}, want);
    endtask

    // Compare process: model check every cycle, plus literal pins per scenario.
    initial begin
        int         p;
        int         d;
        logic       e_tick;
        logic [3:0] e_sel;
        logic [7:0] e_out;
        checks = 0;
        passed = 0;
        forever begin
            @(negedge clk);
            if (valid) begin
                p      = t % CD;
                d      = (t / CD) % N;
                e_tick = (p == CD - 1);
                e_sel  = 4'hF;
                e_out  = 8'hFF;
                if (p != 0 && en_s[d] && !lz_dark(d, hex_s)) begin
                    e_sel[d] = 1'b0;
                    e_out    = ~{dp_s[d], DEC_TAB[hex_s[4*d +: 4]]};
                end
                chk("model", {Scan_tick, Seven_segment_sel, Seven_segment_out}, {e_tick, e_sel, e_out});
                case (phase)
                    1: lit("reset_hold", 13'h0FFF);
                    2: case (t)
                        0:  lit("rel_blank", 13'h0FFF);
                        1:  lit("d0_1234", 13'h0E99);
                        2:  lit("no_tick_yet", 13'h0E99);
                        3:  lit("first_tick", 13'h1E99);
                        5:  lit("d1_1234", 13'h0DB0);
                        9:  lit("d2_1234", 13'h0BA4);
                        13: lit("d3_1234", 13'h07F9);
                        16: lit("frame_blank", 13'h0FFF);
                        17: lit("d0_repeat", 13'h0E99);
                        default: ;
                    endcase
                    3: case (t)
                        0:  lit("midscan_reset", 13'h0FFF);
                        25: lit("d2_disabled_a", 13'h0FFF);
                        26: lit("d2_disabled_b", 13'h0FFF);
                        33: lit("d0_dp", 13'h0E19);
                        default: ;
                    endcase
                    4: case (t)
                        1: lit("restart_d0", 13'h0E99);
                        2: lit("pre_update", 13'h0E99);
                        default: ;
                    endcase
                    5: case (t)
                        3:  lit("live_update", 13'h1E80);
                        5:  lit("d1_unaffected", 13'h0DB0);
                        17: lit("d0_updated", 13'h0E80);
                        default: ;
                    endcase
                    7: case (t)
                        1:  lit("lz_d0", 13'h0EC0);
                        5:  lit("lz_d1", 13'h0D92);
                        9:  lit("lz_d2", LZ_ON ? 13'h0FFF : 13'h0BC0);
                        13: lit("lz_d3", LZ_ON ? 13'h0FFF : 13'h07C0);
                        default: ;
                    endcase
                    default: ;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_t(input int k);
        for (int i = 0; i < 500 && t != k; i++) begin
            step();
        end
    endtask

    initial begin
        logic [15:0] h;
        phase    = 1;
        RESET    = 1'b1;
        Hex_in   = 16'h1234;
        Dp_in    = 4'h0;
        Digit_en = 4'hF;
        repeat (2) step();
        RESET = 1'b0;
        phase = 2;

        wait_t(18);
        Digit_en = 4'b1011;
        Dp_in    = 4'b0001;
        phase    = 3;

        wait_t(41);
        RESET = 1'b1;
        step();
        RESET    = 1'b0;
        Dp_in    = 4'h0;
        Digit_en = 4'hF;
        phase    = 4;

        wait_t(2);
        Hex_in = 16'h1238;
        phase  = 5;

        wait_t(20);
        Hex_in = 16'h0050;
        RESET  = 1'b1;
        phase  = 6;
        step();
        RESET = 1'b0;
        phase = 7;

        wait_t(16);
        phase = 8;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 4; i++) begin
                    h[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
                end
                Hex_in   = h;
                Dp_in    = 4'($urandom_range(0, 15));
                Digit_en = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            end
            RESET = ($urandom_range(0, 149) == 0);
            step();
        end
        RESET = 1'b0;
        phase = 9;
        repeat (3) step();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
